tone_source_arbiter: RTL and testbench
======================================

# tone_source_arbiter

Arbitrates the music box's single tone generator between the manual note keyboard and the song player. Keys preempt song playback; a programmable hold-off then returns the generator to the song. The block also owns the song player's `song_select`/`song_valid` inputs, so it starts, switches and stops songs. It sits between the key scanner/song player and the tone generator.

## Interface
- `HOLD_CYCLES`, default 1200000 — idle cycles after key release before song audio resumes (100 ms at 12 MHz); must be ≥1.
- `GAP_CYCLES`, default 120000 — articulation gap length in cycles (10 ms); must be ≥1; used only with `ARTIC_GAP_EN`.
- `clk` in 1 — system clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `key_note` in 8 — keyboard note code; 0 = REST.
- `key_valid` in 1 — level, high while a key is held.
- `song_req` in 1 — one-cycle pulse requesting song `song_req_id`.
- `song_req_id` in 4 — song number, sampled with `song_req`.
- `stop_req` in 1 — one-cycle pulse that stops song playback.
- `song_note` in 8 — current note from the song player.
- `song_play_en` in 1 — play enable from the song player.
- `song_select` out 4 — song number driven to the player.
- `song_valid` out 1 — song-active flag driven to the player.
- `tone_note` out 8 — note to the tone generator.
- `tone_en` out 1 — tone generator enable.
- `owner` out 2 — current owner: 0 idle, 1 song, 2 key, 3 gap.

## Operation
- States: IDLE, SONG, KEY, HOLD, GAP (GAP exists only with the macro).
- A key is active only when `key_valid`=1 and `key_note`≠0. `key_valid` with note 0 is ignored in every state.
- IDLE:
  - active key → KEY.
  - `song_req` → `song_select`←id, `song_valid`←1, then SONG.
- SONG:
  - `tone_note`←`song_note`; `tone_en`←`song_play_en` & (`song_note`≠0).
  - active key → KEY. `song_valid` stays 1, so the player keeps running, muted.
  - `stop_req` → `song_valid`←0, then IDLE.
  - `song_req` → `song_select`←id; state stays SONG. The player restarts itself on the select change.
- KEY:
  - `tone_note`←`key_note`, `tone_en`←1. A note change while the key is held is applied on the next cycle.
  - key inactive → HOLD, counter←`HOLD_CYCLES`-1.
- HOLD:
  - `tone_en`←0 and `tone_note`←0 throughout.
  - active key → KEY, counter cleared.
  - counter=0 → SONG if `song_valid`=1, else IDLE.
  - otherwise the counter decrements.
- KEY and HOLD:
  - `song_req` latches the new `song_select` and sets `song_valid`←1; state is unchanged.
  - `stop_req` clears `song_valid`; state is unchanged.
- Simultaneous events:
  - `stop_req` and `song_req` together: stop wins; `song_select` is unchanged.
  - active key together with `song_req` in IDLE: the request is latched and the key is served, so the next state is KEY.
- The counter is `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)` bits, unsigned, and never wraps: it saturates at 0.

## Timing
- All outputs are registered. Reset values: `tone_note`=0, `tone_en`=0, `song_select`=0, `song_valid`=0, `owner`=0, state=IDLE, counter=0.
- Latency from any input change to `tone_note`/`tone_en`/`owner` is 1 cycle.
- `song_select`/`song_valid` update 1 cycle after `song_req`/`stop_req`.
- HOLD produces exactly `HOLD_CYCLES` cycles with `tone_en`=0, then song audio follows on the next cycle.
- Asserting `rst_n` mid-note forces reset values asynchronously. No pending request survives reset.

## Configuration
- `ARTIC_GAP_EN` defined:
  - In SONG, a falling edge on `song_play_en` enters GAP for `GAP_CYCLES` cycles, with `tone_en`=0 and `owner`=3. This separates repeated notes audibly.
  - GAP then returns to SONG. An active key preempts GAP → KEY. `stop_req` in GAP → IDLE.
- `ARTIC_GAP_EN` undefined:
  - GAP state and its logic are absent; `owner` never equals 3.
  - Tone follows `song_play_en` directly, so the player's 2-cycle note-boundary drop is the only gap.

## Structure
- Shared package `music_box_pkg` holds:
  - note code constants (REST=0, L1..H2 = 1..16);
  - the owner encoding constants;
  - the arbiter state enum.
- Natural sub-module: `hold_timer`, a loadable, saturating down-counter with a zero flag, shared by HOLD and GAP.

## Test plan
Bench parameters: `HOLD_CYCLES`=8, `GAP_CYCLES`=4.
- Reset asserted mid-KEY → all outputs 0 immediately; IDLE after release.
- `song_req` id=3 from IDLE → `song_select`=3, `song_valid`=1 next cycle; `tone_note` tracks `song_note`=8 with 1-cycle lag; `owner`=1.
- Key note 12 held during SONG → `tone_note`=12, `tone_en`=1, `owner`=2. Release → exactly 8 cycles of `tone_en`=0, then the song note returns.
- Key re-pressed at HOLD cycle 5 → back to KEY; counter restarts at the next release.
- `stop_req` and `song_req` in the same cycle during SONG → `song_valid`=0, IDLE, `song_select` unchanged. `key_valid`=1 with `key_note`=0 → no state change.
- With `ARTIC_GAP_EN`: `song_play_en` falls → `owner`=3 and `tone_en`=0 for 4 cycles, then SONG. Without the macro → `tone_en` drops for only the player's 2 cycles.

Source files
------------

// File: rtl/music_box_pkg.sv
// Shared music box definitions: note codes, tone owner codes, arbiter states.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package music_box_pkg;

  // Note codes: REST, low octave L1..L7, middle M1..M7, high H1..H2
  localparam logic [7:0] NOTE_REST = 8'd0;
  localparam logic [7:0] NOTE_L1 = 8'd1;
  localparam logic [7:0] NOTE_L2 = 8'd2;
  localparam logic [7:0] NOTE_L3 = 8'd3;
  localparam logic [7:0] NOTE_L4 = 8'd4;
  localparam logic [7:0] NOTE_L5 = 8'd5;
  localparam logic [7:0] NOTE_L6 = 8'd6;
  localparam logic [7:0] NOTE_L7 = 8'd7;
  localparam logic [7:0] NOTE_M1 = 8'd8;
  localparam logic [7:0] NOTE_M2 = 8'd9;
  localparam logic [7:0] NOTE_M3 = 8'd10;
  localparam logic [7:0] NOTE_M4 = 8'd11;
  localparam logic [7:0] NOTE_M5 = 8'd12;
  localparam logic [7:0] NOTE_M6 = 8'd13;
  localparam logic [7:0] NOTE_M7 = 8'd14;
  localparam logic [7:0] NOTE_H1 = 8'd15;
  localparam logic [7:0] NOTE_H2 = 8'd16;

  // Who currently drives the tone generator
  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_SONG = 2'd1;
  localparam logic [1:0] OWN_KEY  = 2'd2;
  localparam logic [1:0] OWN_GAP  = 2'd3;

  // Arbiter state encoding (legacy-compatible constant set)
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 3'd0;
  localparam arb_state_t ST_SONG = 3'd1;
  localparam arb_state_t ST_KEY  = 3'd2;
  localparam arb_state_t ST_HOLD = 3'd3;
  localparam arb_state_t ST_GAP  = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_source_arbiter_if.sv
// Bundle between key scanner / song player / tone generator and the arbiter.
// Latency: n/a (wires only).
// Backpressure: none; keys are levels, requests are single-cycle pulses.
interface tone_source_arbiter_if;
  logic [7:0] key_note;
  logic       key_valid;
  logic       song_req;
  logic [3:0] song_req_id;
  logic       stop_req;
  logic [7:0] song_note;
  logic       song_play_en;
  logic [3:0] song_select;
  logic       song_valid;
  logic [7:0] tone_note;
  logic       tone_en;
  logic [1:0] owner;

  // Arbiter side
  modport slave (
    input  key_note, key_valid, song_req, song_req_id, stop_req,
           song_note, song_play_en,
    output song_select, song_valid, tone_note, tone_en, owner
  );

  // Environment side (scanner, player, tone generator)
  modport master (
    output key_note, key_valid, song_req, song_req_id, stop_req,
           song_note, song_play_en,
    input  song_select, song_valid, tone_note, tone_en, owner
  );
endinterface

// File: rtl/tone_source_arbiter_hold_timer.sv
// Loadable saturating down-counter with zero flag (hold-off and gap timing).
// Latency: load/clear/decrement visible 1 cycle later; zero is combinational.
// Backpressure: none.
module hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clear,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Clear beats load beats decrement; decrement sticks at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tone_source_arbiter.sv
// Shares the tone generator between keyboard and song player; keys preempt, hold-off resumes song. Optional ARTIC_GAP_EN adds a gap after each song note.
// Latency: 1 cycle from any input to tone_note/tone_en/owner/song_select/song_valid.
// Backpressure: none; key is a level, song_req/stop_req are pulses acted on the cycle they arrive.
module tone_source_arbiter #(
  parameter int HOLD_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 120000
) (
  input logic                  clk,
  input logic                  rst_n,
  tone_source_arbiter_if.slave bus
);
  import music_box_pkg::*;

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`ifdef ARTIC_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  logic play_en_q;
`endif

  arb_state_t       state, state_nxt;
  logic             key_act;
  logic [3:0]       sel_nxt;
  logic             valid_nxt;
  logic [7:0]       note_nxt;
  logic             en_nxt;
  logic [1:0]       own_nxt;
  logic             tmr_load, tmr_clear, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

  hold_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .clear    (tmr_clear),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Song control: stop wins over a same-cycle request; applies in every state
  always_comb begin
    key_act   = bus.key_valid && (bus.key_note != NOTE_REST);
    sel_nxt   = bus.song_select;
    valid_nxt = bus.song_valid;
    if (bus.stop_req) begin
      valid_nxt = 1'b0;
    end else if (bus.song_req) begin
      valid_nxt = 1'b1;
      sel_nxt   = bus.song_req_id;
    end
  end

  // Next-state and timer control; an active key preempts everything
  always_comb begin
    state_nxt    = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_clear    = 1'b0;
    tmr_dec      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_act)                            state_nxt = ST_KEY;
        else if (bus.song_req && !bus.stop_req) state_nxt = ST_SONG;
      end
      ST_SONG: begin
        if (key_act)           state_nxt = ST_KEY;
        else if (bus.stop_req) state_nxt = ST_IDLE;
`ifdef ARTIC_GAP_EN
        else if (play_en_q && !bus.song_play_en) begin
          state_nxt    = ST_GAP;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end
`endif
      end
      ST_KEY: begin
        if (!key_act) begin
          state_nxt    = ST_HOLD;
          tmr_load     = 1'b1;
          tmr_load_val = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (key_act) begin
          state_nxt = ST_KEY;
          tmr_clear = 1'b1;
        end else if (tmr_zero) begin
          // Resume decision honours a stop/request arriving this same cycle
          state_nxt = valid_nxt ? ST_SONG : ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`ifdef ARTIC_GAP_EN
      ST_GAP: begin
        if (key_act) begin
          state_nxt = ST_KEY;
          tmr_clear = 1'b1;
        end else if (bus.stop_req) begin
          state_nxt = ST_IDLE;
          tmr_clear = 1'b1;
        end else if (tmr_zero) begin
          state_nxt = ST_SONG;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so outputs lag inputs by one cycle
  always_comb begin
    note_nxt = NOTE_REST;
    en_nxt   = 1'b0;
    own_nxt  = OWN_IDLE;
    case (state_nxt)
      ST_SONG: begin
        note_nxt = bus.song_note;
        en_nxt   = bus.song_play_en && (bus.song_note != NOTE_REST);
        own_nxt  = OWN_SONG;
      end
      ST_KEY: begin
        note_nxt = bus.key_note;
        en_nxt   = 1'b1;
        own_nxt  = OWN_KEY;
      end
      // Hold-off is silent but still charged to the keyboard
      ST_HOLD: own_nxt = OWN_KEY;
`ifdef ARTIC_GAP_EN
      ST_GAP:  own_nxt = OWN_GAP;
`endif
      default: ;
    endcase
  end

  // State and registered outputs; reset clears everything including pending song state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      bus.tone_note   <= NOTE_REST;
      bus.tone_en     <= 1'b0;
      bus.owner       <= OWN_IDLE;
      bus.song_select <= 4'd0;
      bus.song_valid  <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.tone_note   <= note_nxt;
      bus.tone_en     <= en_nxt;
      bus.owner       <= own_nxt;
      bus.song_select <= sel_nxt;
      bus.song_valid  <= valid_nxt;
    end
  end

`ifdef ARTIC_GAP_EN
  // Previous play enable, for falling-edge detection in SONG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) play_en_q <= 1'b0;
    else        play_en_q <= bus.song_play_en;
  end
`endif

endmodule

// File: tb/tb_tone_source_arbiter.sv
// Bench for tone_source_arbiter: vector table, hand-written corner sequences, random run vs reference model.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_tone_source_arbiter;
  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_source_arbiter_if bus();

  tone_source_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_note, input logic e_en,
                         input logic [1:0] e_own, input logic [3:0] e_sel, input logic e_vld);
    chk({tag, "_note"},  32'(bus.tone_note),   32'(e_note));
    chk({tag, "_en"},    32'(bus.tone_en),     32'(e_en));
    chk({tag, "_owner"}, 32'(bus.owner),       32'(e_own));
    chk({tag, "_sel"},   32'(bus.song_select), 32'(e_sel));
    chk({tag, "_valid"}, 32'(bus.song_valid),  32'(e_vld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic kv, input logic [7:0] kn, input logic req, input logic [3:0] id,
                        input logic stop, input logic [7:0] sn, input logic pe);
    bus.key_valid = kv;  bus.key_note = kn;
    bus.song_req = req;  bus.song_req_id = id;  bus.stop_req = stop;
    bus.song_note = sn;  bus.song_play_en = pe;
  endtask

  // Counts silent cycles after the current inputs until tone_en returns (bounded)
  task automatic count_silent(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.tone_en === 1'b1) break;
      n++;
    end
  endtask

  typedef struct {
    logic kv; logic [7:0] kn; logic req; logic [3:0] id; logic stop; logic [7:0] sn; logic pe;
    logic [7:0] e_note; logic e_en; logic [1:0] e_own; logic [3:0] e_sel; logic e_vld;
  } vec_t;
  vec_t tbl[12];

  // Reference model: arbitration rules in terms of who owns the generator and silent cycles left
  typedef enum {MD_OFF, MD_SONG, MD_KEY, MD_QUIET, MD_GAP} md_t;
  md_t        m_mode;
  int         m_left;
  logic [3:0] m_sel;
  logic       m_valid, m_prev_pe, m_en;
  logic [7:0] m_note;
  logic [1:0] m_own;

  task automatic model_reset();
    m_mode = MD_OFF; m_left = 0; m_sel = 4'd0; m_valid = 1'b0; m_prev_pe = 1'b0;
    m_note = 8'd0; m_en = 1'b0; m_own = 2'd0;
  endtask

  task automatic model_step();
    logic ka, fell, nv;
    ka   = bus.key_valid && (bus.key_note != 8'd0);
    fell = m_prev_pe && !bus.song_play_en;
    m_prev_pe = bus.song_play_en;
    nv = m_valid;
    if (bus.stop_req) nv = 1'b0;
    else if (bus.song_req) begin nv = 1'b1; m_sel = bus.song_req_id; end
    if (ka) m_mode = MD_KEY;
    else case (m_mode)
      MD_OFF:   if (bus.song_req && !bus.stop_req) m_mode = MD_SONG;
      MD_SONG: begin
        if (bus.stop_req) m_mode = MD_OFF;
`ifdef ARTIC_GAP_EN
        else if (fell) begin m_mode = MD_GAP; m_left = GAP; end
`endif
      end
      MD_KEY:   begin m_mode = MD_QUIET; m_left = HOLD; end
      MD_QUIET: begin
        if (m_left == 1) m_mode = nv ? MD_SONG : MD_OFF;
        else m_left--;
      end
      MD_GAP: begin
        if (bus.stop_req) m_mode = MD_OFF;
        else if (m_left == 1) m_mode = MD_SONG;
        else m_left--;
      end
      default: m_mode = MD_OFF;
    endcase
    m_valid = nv;
    m_note = 8'd0; m_en = 1'b0; m_own = 2'd0;
    case (m_mode)
      MD_SONG:  begin m_note = bus.song_note; m_en = bus.song_play_en && (bus.song_note != 8'd0); m_own = 2'd1; end
      MD_KEY:   begin m_note = bus.key_note; m_en = 1'b1; m_own = 2'd2; end
      MD_QUIET: m_own = 2'd2;
      MD_GAP:   m_own = 2'd3;
      default: ;
    endcase
    if (fell && 1'b0) m_own = 2'd0;
  endtask

  initial begin
    int n;
    //         kv kn     req id    stop sn    pe   note   en   own  sel  vld
    tbl[0]  = '{0, 8'd0,  0, 4'd0, 0, 8'd8, 1,   8'd0,  0, 2'd0, 4'd0, 0};
    tbl[1]  = '{0, 8'd0,  1, 4'd3, 0, 8'd8, 1,   8'd8,  1, 2'd1, 4'd3, 1};
    tbl[2]  = '{0, 8'd0,  0, 4'd0, 0, 8'd8, 1,   8'd8,  1, 2'd1, 4'd3, 1};
    tbl[3]  = '{0, 8'd0,  0, 4'd0, 0, 8'd5, 1,   8'd5,  1, 2'd1, 4'd3, 1};
    tbl[4]  = '{1, 8'd0,  0, 4'd0, 0, 8'd5, 1,   8'd5,  1, 2'd1, 4'd3, 1};
    tbl[5]  = '{1, 8'd12, 0, 4'd0, 0, 8'd5, 1,   8'd12, 1, 2'd2, 4'd3, 1};
    tbl[6]  = '{1, 8'd12, 1, 4'd7, 0, 8'd5, 1,   8'd12, 1, 2'd2, 4'd7, 1};
    tbl[7]  = '{1, 8'd14, 0, 4'd0, 0, 8'd5, 1,   8'd14, 1, 2'd2, 4'd7, 1};
    tbl[8]  = '{0, 8'd14, 0, 4'd0, 0, 8'd5, 1,   8'd0,  0, 2'd2, 4'd7, 1};
    tbl[9]  = '{0, 8'd0,  0, 4'd0, 1, 8'd5, 1,   8'd0,  0, 2'd2, 4'd7, 0};
    tbl[10] = '{0, 8'd0,  1, 4'd9, 1, 8'd5, 1,   8'd0,  0, 2'd2, 4'd7, 0};
    tbl[11] = '{0, 8'd0,  1, 4'd2, 0, 8'd5, 1,   8'd0,  0, 2'd2, 4'd2, 1};

    set_in(0, 8'd0, 0, 4'd0, 0, 8'd0, 0);
    tick();
    chk_out("reset", 8'd0, 0, 2'd0, 4'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].kv, tbl[i].kn, tbl[i].req, tbl[i].id, tbl[i].stop, tbl[i].sn, tbl[i].pe);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].e_note, tbl[i].e_en, tbl[i].e_own, tbl[i].e_sel, tbl[i].e_vld);
    end

    // Reset asserted mid-KEY clears outputs at once; nothing pending survives
    set_in(1, 8'd3, 0, 4'd0, 0, 8'd8, 1);
    tick();
    chk_out("pre_rst_key", 8'd3, 1, 2'd2, 4'd2, 1);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 8'd0, 0, 2'd0, 4'd0, 0);
    tick();
    set_in(0, 8'd0, 0, 4'd0, 0, 8'd8, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("post_rst_idle", 8'd0, 0, 2'd0, 4'd0, 0);

    // Song start, key preempt, release gives exactly HOLD silent cycles
    bus.song_req = 1'b1; bus.song_req_id = 4'd3;
    tick();
    bus.song_req = 1'b0;
    chk_out("song_start", 8'd8, 1, 2'd1, 4'd3, 1);
    bus.key_valid = 1'b1; bus.key_note = 8'd12;
    tick();
    chk_out("key_preempt", 8'd12, 1, 2'd2, 4'd3, 1);
    bus.key_valid = 1'b0;
    count_silent(n);
    chk("hold_len", n, HOLD);
    chk("hold_resume_note", 32'(bus.tone_note), 32'd8);
    chk("hold_resume_owner", 32'(bus.owner), 32'd1);

    // Re-press during hold-off cycle 5, then a full hold-off after the next release
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("hold4_en", 32'(bus.tone_en), 32'd0);
    chk("hold4_owner", 32'(bus.owner), 32'd2);
    bus.key_valid = 1'b1;
    tick();
    chk_out("repress", 8'd12, 1, 2'd2, 4'd3, 1);
    bus.key_valid = 1'b0;
    count_silent(n);
    chk("hold_restart_len", n, HOLD);

    // Stop and request together: stop wins, select kept; note-0 key ignored
    bus.stop_req = 1'b1; bus.song_req = 1'b1; bus.song_req_id = 4'd11;
    tick();
    bus.stop_req = 1'b0; bus.song_req = 1'b0;
    chk_out("stop_wins", 8'd0, 0, 2'd0, 4'd3, 0);
    bus.key_valid = 1'b1; bus.key_note = 8'd0;
    for (int k = 0; k < 3; k++) tick();
    chk_out("rest_key_ignored", 8'd0, 0, 2'd0, 4'd3, 0);
    bus.key_valid = 1'b0;

    // Play-enable drop: articulation gap when enabled, else only the player's drop
    bus.song_req = 1'b1; bus.song_req_id = 4'd5;
    tick();
    bus.song_req = 1'b0;
    chk_out("song2_start", 8'd8, 1, 2'd1, 4'd5, 1);
    bus.song_play_en = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 1) bus.song_play_en = 1'b1;
`ifdef ARTIC_GAP_EN
      if (k == 0) chk("gap_owner", 32'(bus.owner), 32'd3);
`else
      if (k == 0) chk("drop_owner", 32'(bus.owner), 32'd1);
`endif
      if (bus.tone_en === 1'b1) break;
      n++;
    end
`ifdef ARTIC_GAP_EN
    chk("gap_len", n, GAP);
`else
    chk("drop_len", n, 2);
`endif

    // Random run against the reference model
    rst_n = 1'b0;
    set_in(0, 8'd0, 0, 4'd0, 0, 8'd0, 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) bus.key_valid = ~bus.key_valid;
      if ($urandom_range(0, 5) == 0)
        bus.key_note = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 16));
      bus.song_req    = ($urandom_range(0, 14) == 0);
      bus.song_req_id = 4'($urandom_range(0, 15));
      bus.stop_req    = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) bus.song_note = 8'($urandom_range(0, 16));
      if ($urandom_range(0, 5) == 0) bus.song_play_en = ~bus.song_play_en;
      @(posedge clk);
      model_step();
      #1;
      chk_out($sformatf("rnd%0d", c), m_note, m_en, m_own, m_sel, m_valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
